// File: rtl/fwd_ctrl.sv
// fwd_ctrl
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Keeps a registered shadow of the register-usage fields of the
// instructions in EX, MEM and WB, and from it derives the EX-stage
// operand-select codes and the load-use stall request.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          asynchronous active-high reset
//   id_valid_i     ID slot holds a real instruction
//   id_rs1_i       ID source register 1
//   id_rs2_i       ID source register 2
//   id_rd_i        ID destination register
//   id_regwrite_i  ID instruction writes the register file
//   id_memread_i   ID instruction is a load
//   flush_i        discard the ID instruction (taken branch)
//   stall_o        load-use stall request (combinational)
//   fwd_a_o        operand A select: 10 EX/MEM, 01 MEM/WB, 00 regfile
//   fwd_b_o        operand B select, same encoding
//   stall_cnt_o    saturating stall-cycle counter (FWD_STALL_CNT_EN only)
//
// Build option: define FWD_STALL_CNT_EN to add the stall counter.

module fwd_ctrl #(
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt_o
`endif
);

    localparam logic [1:0] SEL_REGFILE = 2'b00;
    localparam logic [1:0] SEL_MEMWB   = 2'b01;
    localparam logic [1:0] SEL_EXMEM   = 2'b10;

    // EX slot: the only slot whose sources and load flag are consulted.
    logic [REG_AW-1:0] exRs1_q, exRs1_d;
    logic [REG_AW-1:0] exRs2_q, exRs2_d;
    logic [REG_AW-1:0] exRd_q, exRd_d;
    logic              exRegWrite_q, exRegWrite_d;
    logic              exMemRead_q, exMemRead_d;

    // MEM and WB slots only ever act as producers, so a load flag kept
    // there would never be read; only rd and regwrite are held.
    logic [REG_AW-1:0] memRd_q;
    logic              memRegWrite_q;
    logic [REG_AW-1:0] wbRd_q;
    logic              wbRegWrite_q;

    // Select code for one EX source. The MEM producer is the younger of
    // the two, so its value wins when both write the same register.
    // Register x0 is hard-wired to zero and never forwards.
    function automatic logic [1:0] selFor(
        input logic [REG_AW-1:0] rs,
        input logic              memRw,
        input logic [REG_AW-1:0] memRd,
        input logic              wbRw,
        input logic [REG_AW-1:0] wbRd
    );
        logic [1:0] sel;
        sel = SEL_REGFILE;
        if (memRw && (memRd != '0) && (memRd == rs)) begin
            sel = SEL_EXMEM;
        end else if (wbRw && (wbRd != '0) && (wbRd == rs)) begin
            sel = SEL_MEMWB;
        end
        return sel;
    endfunction

    // A load in EX whose result the ID instruction needs cannot be
    // forwarded in time, so ID is held for one cycle. A flushed ID
    // instruction is being thrown away and must never stall.
    always_comb begin
        stall_o = exMemRead_q && (exRd_q != '0) && id_valid_i && !flush_i &&
                  ((exRd_q == id_rs1_i) || (exRd_q == id_rs2_i));
    end

    // Selects come purely from registered state, stable all cycle.
    always_comb begin
        fwd_a_o = selFor(exRs1_q, memRegWrite_q, memRd_q, wbRegWrite_q, wbRd_q);
        fwd_b_o = selFor(exRs2_q, memRegWrite_q, memRd_q, wbRegWrite_q, wbRd_q);
    end

    // Next EX contents: the ID instruction, or a bubble when it is
    // stalled, flushed or not a real instruction.
    always_comb begin
        exRs1_d      = '0;
        exRs2_d      = '0;
        exRd_d       = '0;
        exRegWrite_d = 1'b0;
        exMemRead_d  = 1'b0;
        if (id_valid_i && !flush_i && !stall_o) begin
            exRs1_d      = id_rs1_i;
            exRs2_d      = id_rs2_i;
            exRd_d       = id_rd_i;
            exRegWrite_d = id_regwrite_i;
            exMemRead_d  = id_memread_i;
        end
    end

    // Slot pipeline: MEM and WB always advance; reset empties every slot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            exRs1_q       <= '0;
            exRs2_q       <= '0;
            exRd_q        <= '0;
            exRegWrite_q  <= 1'b0;
            exMemRead_q   <= 1'b0;
            memRd_q       <= '0;
            memRegWrite_q <= 1'b0;
            wbRd_q        <= '0;
            wbRegWrite_q  <= 1'b0;
        end else begin
            exRs1_q       <= exRs1_d;
            exRs2_q       <= exRs2_d;
            exRd_q        <= exRd_d;
            exRegWrite_q  <= exRegWrite_d;
            exMemRead_q   <= exMemRead_d;
            memRd_q       <= exRd_q;
            memRegWrite_q <= exRegWrite_q;
            wbRd_q        <= memRd_q;
            wbRegWrite_q  <= memRegWrite_q;
        end
    end

`ifdef FWD_STALL_CNT_EN
    logic [31:0] stallCnt_q, stallCnt_d;

    // Counts stall cycles, holding at all-ones rather than wrapping.
    always_comb begin
        stallCnt_d = stallCnt_q;
        if (stall_o && (stallCnt_q != 32'hFFFF_FFFF)) begin
            stallCnt_d = stallCnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stallCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end

    assign stall_cnt_o = stallCnt_q;
`endif

endmodule

// File: doc/fwd_ctrl.md
# fwd_ctrl

Forwarding and load-use hazard controller for the 5-stage pipelined CPU. It keeps a registered shadow copy of the register-usage fields of the instructions in EX, MEM and WB. From that state it generates the 2-bit operand-select codes that drive the EX-stage 4:1 operand multiplexers for ALU operands A and B. It also raises the load-use stall request consumed by the PC / IF-ID write enables.

## Interface
Parameters:
- `REG_AW`, default 5: register index width.

Ports:
- `clk_i`, input, 1: clock, rising edge.
- `rst_i`, input, 1: reset; asynchronous, active-high.
- `id_valid_i`, input, 1: the ID-stage slot holds a real instruction.
- `id_rs1_i`, input, REG_AW: ID instruction source register 1.
- `id_rs2_i`, input, REG_AW: ID instruction source register 2.
- `id_rd_i`, input, REG_AW: ID instruction destination register.
- `id_regwrite_i`, input, 1: ID instruction writes the register file.
- `id_memread_i`, input, 1: ID instruction is a load.
- `flush_i`, input, 1: discard the ID instruction (taken branch).
- `stall_o`, output, 1: load-use stall request (combinational).
- `fwd_a_o`, output, 2: select code for operand A of the instruction in EX.
- `fwd_b_o`, output, 2: select code for operand B of the instruction in EX.
- `stall_cnt_o`, output, 32: stall-cycle counter. Present only with `FWD_STALL_CNT_EN`.

## Operation
- Internal slots are `ex`, `mem` and `wb`.
  - Each slot holds rd, regwrite and memread.
  - `ex` additionally holds rs1 and rs2.
- A bubble is a slot with regwrite = 0, memread = 0 and every index = 0.
- Per-clock update:
  - `wb` <= `mem` and `mem` <= `ex`, unconditionally.
  - `ex` <= bubble if `stall_o` = 1, `flush_i` = 1 or `id_valid_i` = 0.
  - Otherwise `ex` <= the ID fields.
- Stall condition:
  - `stall_o` = ex.memread & (ex.rd != 0) & id_valid_i & !flush_i & (ex.rd == id_rs1_i | ex.rd == id_rs2_i).
  - `flush_i` overrides `stall_o`: a flushed instruction never stalls.
- Select encoding, identical for A (compared against ex.rs1) and B (compared against ex.rs2):
  - `10`: EX/MEM ALU result, when mem.regwrite & mem.rd != 0 & mem.rd == ex.rsN.
  - `01`: MEM/WB write-back data, when the `10` condition is false and wb.regwrite & wb.rd != 0 & wb.rd == ex.rsN.
  - `00`: register-file value, otherwise.
  - `11`: reserved, never driven.
- Register x0 never forwards, whatever regwrite says.
- `fwd_a_o` / `fwd_b_o` depend only on registered state, so they are stable for the whole cycle.

## Timing
- Reset (asynchronous, takes effect immediately):
  - all slots become bubbles;
  - `fwd_a_o` = `fwd_b_o` = 00;
  - `stall_o` = 0 while `id_valid_i` = 0 or the inputs do not match;
  - `stall_cnt_o` = 0.
- Reset mid-operation discards all tracked instructions. The first instruction after reset sees 00 selects.
- Forward latency:
  - a producer one instruction ahead of the consumer gives `10` in the cycle the consumer is in EX;
  - a producer two instructions ahead gives `01`;
  - a producer three or more ahead gives `00` (the register file writes first half and reads second half).
- Load-use:
  - `stall_o` is high for exactly one cycle per dependent pair;
  - the consumer enters EX two cycles after the stall cycle began, with select `01`.
- Back-to-back loads with chained dependencies each stall one cycle. There is no cumulative state beyond the slots.

## Configuration
- `FWD_STALL_CNT_EN` defined:
  - `stall_cnt_o` exists;
  - it increments by 1 on every clock edge where `stall_o` = 1;
  - it saturates at 32'hFFFF_FFFF;
  - it is cleared only by `rst_i`.
- `FWD_STALL_CNT_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset:
  - stimulus: pulse `rst_i` asynchronously mid-stream with x5 pending in `mem`;
  - response: selects go to 00 immediately, the next consumer of x5 gets 00, and `stall_cnt_o` reads 0.
- Distance-1 and distance-2 forwarding:
  - stimulus: add x5,x1,x2 then sub x6,x5,x3;
  - response: the sub in EX gives `fwd_a_o` = 10 and `fwd_b_o` = 00;
  - variant: insert one independent instruction between them; response: `fwd_a_o` = 01.
- Priority:
  - stimulus: add x5 ; or x5 ; and x7,x5,x5;
  - response: the and in EX gives `fwd_a_o` = `fwd_b_o` = 10, not 01.
- Load-use:
  - stimulus: lw x7,0(x1) then add x8,x7,x1;
  - response: `stall_o` = 1 for one cycle, then the add in EX gives `fwd_a_o` = 01;
  - with the macro: `stall_cnt_o` = 1.
- x0 and flush:
  - stimulus: add x0,x1,x2 then sub x3,x0,x0;
  - response: the sub in EX gives selects 00;
  - stimulus: lw x7 with a dependent add in ID and `flush_i` = 1;
  - response: `stall_o` = 0, and the next `ex` is a bubble.
